// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: memory-wait freeze, taken-branch flush, load-use bubble.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IdRs,
   input  logic [4:0]       IdRt,
   input  logic             ExMemRead,
   input  logic [4:0]       ExRd,
   input  logic [1:0]       MemMem,
   input  logic             MemBranch,
   input  logic             MemZero,
   input  logic             DmemReady,
   output logic             DmemReq,
   output logic             PcWrite,
   output logic             PcSrc,
   output logic             IfIdWrite,
   output logic             IdExWrite,
   output logic             ExMemWrite,
   output logic             IdExBubble,
   output logic             IfIdFlush,
   output logic             IdExFlush,
   output logic             ExMemFlush,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

   state_t      r_state;
   logic [7:0]  r_waitCnt;
   logic        r_memErr;

   state_t      w_nextState;
   logic [7:0]  w_nextCnt;
   logic        w_setErr;
   logic        w_memOp;
   logic        w_loadUse;
   logic        w_enable;
   logic        w_stallFront;
   logic        w_flush;

   // Reset forces the free-running outputs regardless of the current state.
   always_comb begin
      w_memOp      = |MemMem;
      w_loadUse    = ExMemRead && (ExRd != 5'd0) && ((ExRd == IdRs) || (ExRd == IdRt));
      w_enable     = 1'b1;
      w_stallFront = 1'b0;
      w_flush      = 1'b0;
      DmemReq      = 1'b0;
      PcSrc        = 1'b0;
      IdExBubble   = 1'b0;
      w_nextState  = r_state;
      w_nextCnt    = r_waitCnt;
      w_setErr     = 1'b0;
      if (!rst) begin
         case (r_state)
            RUN: begin
               DmemReq = w_memOp;
               if (w_memOp && !DmemReady) begin
                  w_enable    = 1'b0;
                  w_nextState = MEM_WAIT;
                  w_nextCnt   = 8'd1;
               end else if (MemBranch && MemZero) begin
                  PcSrc   = 1'b1;
                  w_flush = 1'b1;
               end else if (w_loadUse) begin
                  w_stallFront = 1'b1;
                  IdExBubble   = 1'b1;
               end
            end
            MEM_WAIT: begin
               DmemReq = 1'b1;
               if (DmemReady) begin
                  w_nextState = RUN;
                  w_nextCnt   = 8'd0;
               end else if (r_waitCnt == TIMEOUT_VAL) begin
                  w_setErr    = 1'b1;
                  w_nextState = RUN;
                  w_nextCnt   = 8'd0;
               end else begin
                  w_enable  = 1'b0;
                  w_nextCnt = r_waitCnt + 8'd1;
               end
            end
            default: begin
               w_nextState = RUN;
               w_nextCnt   = 8'd0;
            end
         endcase
      end
      PcWrite    = w_enable && !w_stallFront;
      IfIdWrite  = w_enable && !w_stallFront;
      IdExWrite  = w_enable;
      ExMemWrite = w_enable;
      IfIdFlush  = w_flush;
      IdExFlush  = w_flush;
      ExMemFlush = w_flush;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RUN;
         r_waitCnt <= 8'd0;
         r_memErr  <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_nextCnt;
         if (w_setErr)
            r_memErr <= 1'b1;
      end
   end

   assign MemErr = r_memErr;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   // Both counters saturate rather than wrap so a long run never reads as a short one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if ((!PcWrite || !ExMemWrite) && (r_stallCnt != '1))
            r_stallCnt <= r_stallCnt + 1'b1;
         if (PcSrc && (r_flushCnt != '1))
            r_flushCnt <= r_flushCnt + 1'b1;
      end
   end

   assign StallCnt = r_stallCnt;
   assign FlushCnt = r_flushCnt;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with hand-computed control vectors.
// Built with MEM_TIMEOUT = 4; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 16;

   // Control vector order: {DmemReq, PcWrite, PcSrc, IfIdWrite, IdExWrite, ExMemWrite,
   //                        IdExBubble, IfIdFlush, IdExFlush, ExMemFlush}
   localparam logic [9:0] NORMAL  = 10'b0_1_0_1_1_1_0_000;
   localparam logic [9:0] MEMGO   = 10'b1_1_0_1_1_1_0_000;
   localparam logic [9:0] FREEZE  = 10'b1_0_0_0_0_0_0_000;
   localparam logic [9:0] LOADUSE = 10'b0_0_0_0_1_1_1_000;
   localparam logic [9:0] BRANCH  = 10'b0_1_1_1_1_1_0_111;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [4:0]       IdRs;
   logic [4:0]       IdRt;
   logic             ExMemRead;
   logic [4:0]       ExRd;
   logic [1:0]       MemMem;
   logic             MemBranch;
   logic             MemZero;
   logic             DmemReady;
   logic             DmemReq;
   logic             PcWrite;
   logic             PcSrc;
   logic             IfIdWrite;
   logic             IdExWrite;
   logic             ExMemWrite;
   logic             IdExBubble;
   logic             IfIdFlush;
   logic             IdExFlush;
   logic             ExMemFlush;
   logic             MemErr;
   logic [CNT_W-1:0] StallCnt;
   logic [CNT_W-1:0] FlushCnt;

   logic [9:0]       ctrlObs;
   int               checkCount;
   int               errorCount;
   int               expStall;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .IdRs       (IdRs),
      .IdRt       (IdRt),
      .ExMemRead  (ExMemRead),
      .ExRd       (ExRd),
      .MemMem     (MemMem),
      .MemBranch  (MemBranch),
      .MemZero    (MemZero),
      .DmemReady  (DmemReady),
      .DmemReq    (DmemReq),
      .PcWrite    (PcWrite),
      .PcSrc      (PcSrc),
      .IfIdWrite  (IfIdWrite),
      .IdExWrite  (IdExWrite),
      .ExMemWrite (ExMemWrite),
      .IdExBubble (IdExBubble),
      .IfIdFlush  (IfIdFlush),
      .IdExFlush  (IdExFlush),
      .ExMemFlush (ExMemFlush),
      .MemErr     (MemErr),
      .StallCnt   (StallCnt),
      .FlushCnt   (FlushCnt)
   );

   assign ctrlObs = {DmemReq, PcWrite, PcSrc, IfIdWrite, IdExWrite, ExMemWrite,
                     IdExBubble, IfIdFlush, IdExFlush, ExMemFlush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic exRead,
                                input logic [4:0] exRd, input logic [1:0] mem,
                                input logic br, input logic zero, input logic ready);
      IdRs      = rs;
      IdRt      = rt;
      ExMemRead = exRead;
      ExRd      = exRd;
      MemMem    = mem;
      MemBranch = br;
      MemZero   = zero;
      DmemReady = ready;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      expStall   = 0;

      // Reset overrides an in-flight memory op on the inputs.
      rst = 1'b1;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0);
      checkOutput("reset ctrl", 32'(ctrlObs), 32'(NORMAL));
      checkOutput("reset memErr", 32'(MemErr), 32'd0);
      checkOutput("reset stallCnt", 32'(StallCnt), 32'd0);
      checkOutput("reset flushCnt", 32'(FlushCnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(5'd1, 5'd2, 1'b0, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("idle", 32'(ctrlObs), 32'(NORMAL));
      tick();

      // Load-use on rs, then on rt, then the ExRd == 0 and no-match cases.
      applyStimulus(5'd5, 5'd7, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("loaduse rs", 32'(ctrlObs), 32'(LOADUSE));
      expStall++;
      tick();
      applyStimulus(5'd5, 5'd7, 1'b0, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("after loaduse", 32'(ctrlObs), 32'(NORMAL));
      tick();
      applyStimulus(5'd3, 5'd9, 1'b1, 5'd9, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("loaduse rt", 32'(ctrlObs), 32'(LOADUSE));
      expStall++;
      tick();
      applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("loaduse r0", 32'(ctrlObs), 32'(NORMAL));
      tick();
      applyStimulus(5'd4, 5'd6, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("load no match", 32'(ctrlObs), 32'(NORMAL));
      tick();

      // Read with three not-ready cycles, released on the ready cycle.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("memwait %0d", i), 32'(ctrlObs), 32'(FREEZE));
         expStall++;
         tick();
      end
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1);
      checkOutput("memwait ready", 32'(ctrlObs), 32'(MEMGO));
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("after memwait", 32'(ctrlObs), 32'(NORMAL));
      checkOutput("stallCnt memwait", 32'(StallCnt), PERF_ON ? 32'(expStall) : 32'd0);
      tick();

      // Taken branch wins over a concurrent load-use; a not-taken branch does not.
      applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0);
      checkOutput("branch taken", 32'(ctrlObs), 32'(BRANCH));
      tick();
      checkOutput("flushCnt branch", 32'(FlushCnt), PERF_ON ? 32'd1 : 32'd0);
      applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("branch not taken", 32'(ctrlObs), 32'(LOADUSE));
      expStall++;
      tick();

      // Memory wait outranks a taken branch, and the branch is ignored in MEM_WAIT.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b1, 1'b1, 1'b0);
      checkOutput("mem over branch", 32'(ctrlObs), 32'(FREEZE));
      expStall++;
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b1, 1'b1, 1'b1);
      checkOutput("wait ignores branch", 32'(ctrlObs), 32'(MEMGO));
      tick();
      checkOutput("flushCnt unchanged", 32'(FlushCnt), PERF_ON ? 32'd1 : 32'd0);

      // Zero-latency access: no stall, and the next idle cycle proves the FSM stayed in RUN.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1);
      checkOutput("zero latency", 32'(ctrlObs), 32'(MEMGO));
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("after zero latency", 32'(ctrlObs), 32'(NORMAL));
      tick();

      // Write that never completes: four frozen cycles, then abort with MemErr.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("timeout wait %0d", i), 32'(ctrlObs), 32'(FREEZE));
         expStall++;
         tick();
      end
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout abort", 32'(ctrlObs), 32'(MEMGO));
      checkOutput("memErr before abort", 32'(MemErr), 32'd0);
      tick();
      checkOutput("memErr set", 32'(MemErr), 32'd1);
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("after timeout", 32'(ctrlObs), 32'(NORMAL));
      tick();
      tick();
      checkOutput("memErr sticky", 32'(MemErr), 32'd1);
      checkOutput("stallCnt total", 32'(StallCnt), PERF_ON ? 32'(expStall) : 32'd0);

      // Reset while waiting on memory.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0);
      checkOutput("pre-reset wait", 32'(ctrlObs), 32'(FREEZE));
      tick();
      checkOutput("in wait", 32'(ctrlObs), 32'(FREEZE));
      rst = 1'b1;
      #1;
      checkOutput("reset mid-wait ctrl", 32'(ctrlObs), 32'(NORMAL));
      checkOutput("reset mid-wait memErr", 32'(MemErr), 32'd0);
      checkOutput("reset mid-wait stallCnt", 32'(StallCnt), 32'd0);
      checkOutput("reset mid-wait flushCnt", 32'(FlushCnt), 32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("after reset run", 32'(ctrlObs), 32'(NORMAL));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.
- Handshakes with a variable-latency data memory and freezes the pipeline while an access is outstanding.
- Detects load-use hazards and taken branches resolved in MEM. Keeps a timeout watchdog and optional performance counters.

Parameters:
- MEM_TIMEOUT, 15: wait cycles in MEM_WAIT before the access is aborted and MemErr is raised (range 1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- IdRs  in  5  rs field of the instruction in ID
- IdRt  in  5  rt field of the instruction in ID
- ExMemRead  in  1  instruction in EX is a load
- ExRd  in  5  destination register of the instruction in EX
- MemMem  in  2  MEM-stage memory control; bit1 = read, bit0 = write
- MemBranch  in  1  MEM-stage instruction is a branch
- MemZero  in  1  ALU zero flag latched into MEM
- DmemReady  in  1  data memory completes the current access this cycle
- DmemReq  out  1  data memory access request
- PcWrite  out  1  PC load enable
- PcSrc  out  1  select branch target for the PC
- IfIdWrite  out  1  IF/ID load enable
- IdExWrite  out  1  ID/EX load enable
- ExMemWrite  out  1  EX/MEM load enable
- IdExBubble  out  1  zero the control fields entering ID/EX
- IfIdFlush  out  1  clear IF/ID
- IdExFlush  out  1  clear ID/EX
- ExMemFlush  out  1  clear EX/MEM
- MemErr  out  1  sticky memory timeout flag
- StallCnt  out  CNT_W  total stall cycles
- FlushCnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (async, while rst=1):
  - state = RUN; wait counter = 0; MemErr = 0; StallCnt = FlushCnt = 0.
  - Outputs forced: all *Write = 1, all flushes/bubble/PcSrc/DmemReq = 0.
- FSM states: RUN, MEM_WAIT. The state is registered; all other control outputs are combinational from state and inputs.
- memop = MemMem != 0.
- RUN:
  - DmemReq = memop.
  - If memop && !DmemReady:
    - next state = MEM_WAIT; wait counter <= 1.
    - Freeze this cycle: PcWrite = IfIdWrite = IdExWrite = ExMemWrite = 0; no flush, no bubble.
  - Else if MemBranch && MemZero (taken branch):
    - PcSrc = 1; IfIdFlush = IdExFlush = ExMemFlush = 1; all enables = 1.
    - A simultaneous load-use hazard is ignored, because the flush kills the dependent instruction.
  - Else if load-use hazard, i.e. ExMemRead && ExRd != 0 && (ExRd == IdRs || ExRd == IdRt):
    - PcWrite = IfIdWrite = 0; IdExBubble = 1; IdExWrite = ExMemWrite = 1.
  - Else all enables = 1, everything else 0.
- MEM_WAIT:
  - DmemReq = 1. All enables = DmemReady; flushes and bubble = 0.
  - DmemReady = 1: release in the same cycle; next state = RUN; wait counter <= 0.
  - !DmemReady and wait counter == MEM_TIMEOUT: MemErr <= 1 (sticky until rst); enables = 1 (abort, pipeline advances); next state = RUN.
  - Otherwise the wait counter increments.
- Priority: memory wait > taken branch > load-use.
- A branch is never sampled in MEM_WAIT (MEM holds a memory op).
- Zero-latency memory (DmemReady high in the first request cycle) causes no stall.
- Reset asserted mid-wait aborts immediately to RUN with the reset values above.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - StallCnt increments in every cycle where PcWrite = 0 or ExMemWrite = 0.
  - FlushCnt increments on every taken-branch cycle.
  - Both saturate at all-ones.
- Undefined: StallCnt and FlushCnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset mid-wait: assert rst while in MEM_WAIT -> next cycle PcWrite = 1, DmemReq = 0, MemErr = 0, state RUN.
- Load-use: ExMemRead = 1, ExRd = 5, IdRs = 5 -> PcWrite = 0, IfIdWrite = 0, IdExBubble = 1 for 1 cycle. Repeat with ExRd = 0 -> no stall.
- Memory wait: MemMem = 2'b10, DmemReady low for 3 cycles then high -> enables low for 3 cycles, high on the ready cycle, DmemReq high for 4 cycles; StallCnt = 3 with PIPE_PERF_CNT_EN defined.
- Taken branch: MemBranch = 1, MemZero = 1 with a concurrent load-use hazard -> PcSrc = 1, all three flushes = 1, IdExBubble = 0, FlushCnt = 1.
- Timeout: MEM_TIMEOUT = 4, MemMem = 2'b01, DmemReady held low -> enables = 0 for 4 cycles; in the 5th cycle enables = 1 and MemErr rises and stays 1 until reset.
- Zero-latency memory: MemMem = 2'b10 with DmemReady = 1 in the same cycle -> no stall, state stays RUN.
